// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit instruction word.
// Two-stage valid/ready pipeline. S1 captures the fields and the immediate check
// flags; S2 captures the packed word and error bits. A word that fails any check
// is replaced by NOP_WORD, and its error bits are still reported.
module inst_encoder #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  // Field input
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  // Instruction output
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [2:0]       out_err,
  // Statistics
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  // Format codes carried on in_fmt; 6 and 7 are illegal.
  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;

  // Error bit positions in out_err.
  localparam int unsigned ErrRange = 0;
  localparam int unsigned ErrAlign = 1;
  localparam int unsigned ErrFmt   = 2;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_adv;
  logic accept;
  logic handoff;

  // S2 frees up when empty or draining; S1 frees up when empty or moving into S2.
  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign handoff  = s2_valid_q && out_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: immediate checks on the incoming fields
  // ---------------------------------------------------------------------------
  logic [2:0] chk_err;

  // A field of sign bits fits only if every bit equals the sign.
  function automatic logic all_same(input logic [31:0] v, input int unsigned lsb);
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int unsigned b = 0; b < 32; b++) begin
      if (b >= lsb) begin
        ones  = ones & v[b];
        zeros = zeros & ~v[b];
      end
    end
    return ones | zeros;
  endfunction

  // Range, alignment and format checks decoded from the incoming format.
  always_comb begin
    chk_err = '0;
    case (in_fmt)
      FmtR: chk_err = '0;
      FmtI, FmtS: begin
        chk_err[ErrRange] = !all_same(in_imm, 11);
      end
      FmtB: begin
        chk_err[ErrRange] = !all_same(in_imm, 12);
        chk_err[ErrAlign] = in_imm[0];
      end
      FmtJ: begin
        chk_err[ErrRange] = !all_same(in_imm, 20);
        chk_err[ErrAlign] = in_imm[0];
      end
      FmtU: begin
        chk_err[ErrAlign] = |in_imm[11:0];
      end
      default: begin
        chk_err[ErrFmt] = 1'b1;
      end
    endcase
  end

  logic [2:0]  s1_fmt_q;
  logic [6:0]  s1_opcode_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic [31:0] s1_imm_q;
  logic [2:0]  s1_err_q;

  // S1 register: valid follows in_valid whenever the stage may load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= '0;
      s1_opcode_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s1_imm_q    <= '0;
      s1_err_q    <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (accept) begin
        s1_fmt_q    <= in_fmt;
        s1_opcode_q <= in_opcode;
        s1_rd_q     <= in_rd;
        s1_rs1_q    <= in_rs1;
        s1_rs2_q    <= in_rs2;
        s1_funct3_q <= in_funct3;
        s1_funct7_q <= in_funct7;
        s1_imm_q    <= in_imm;
        s1_err_q    <= chk_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: packing
  // ---------------------------------------------------------------------------
  logic [31:0] pack_word;
  logic [31:0] im;

  assign im = s1_imm_q;

  // Scatter the immediate per format; any error substitutes the NOP.
  always_comb begin
    pack_word = NOP_WORD;
    case (s1_fmt_q)
      FmtR: pack_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FmtI: pack_word = {im[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FmtS: pack_word = {im[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, im[4:0], s1_opcode_q};
      FmtB: pack_word = {im[12], im[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, im[4:1], im[11],
                         s1_opcode_q};
      FmtU: pack_word = {im[31:12], s1_rd_q, s1_opcode_q};
      FmtJ: pack_word = {im[20], im[10:1], im[11], im[19:12], s1_rd_q, s1_opcode_q};
      default: pack_word = NOP_WORD;
    endcase
    if (|s1_err_q) begin
      pack_word = NOP_WORD;
    end
  end

  logic [31:0] s2_inst_q;
  logic [2:0]  s2_err_q;

  // S2 register: loads only when S1 moves forward, so a stalled word holds steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= '0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_q <= pack_word;
        s2_err_q  <= s1_err_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;

  // ---------------------------------------------------------------------------
  // Handoff counters (wrap naturally)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] enc_count_q;
  logic [CNT_W-1:0] err_count_q;

  // Count each word once as it leaves, split on whether it carried an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count_q <= '0;
      err_count_q <= '0;
    end else if (handoff) begin
      if (s2_err_q == 3'b000) begin
        enc_count_q <= enc_count_q + CNT_W'(1);
      end else begin
        err_count_q <= err_count_q + CNT_W'(1);
      end
    end
  end

  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: single words of every format, error cases,
// a back-to-back burst under backpressure, and reset with words in flight.
module tb_inst_encoder;

  localparam int unsigned CntW = 16;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_fmt;
  logic [6:0]      in_opcode;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [31:0]     in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [2:0]      out_err;
  logic [CntW-1:0] enc_count;
  logic [CntW-1:0] err_count;

  inst_encoder #(
    .CNT_W    (CntW),
    .NOP_WORD (32'h00000013)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  int exp_enc;
  int exp_errc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt    = fmt;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  // One word through an empty pipeline with out_ready held high.
  task automatic single(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_inst, input logic [2:0] exp_err);
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    check({tag, " ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check({tag, " s1 only"}, 32'(out_valid), 32'd0);
    step();
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " inst"}, out_inst, exp_inst);
    check({tag, " err"}, 32'(out_err), 32'(exp_err));
    if (exp_err == 3'b000) exp_enc++;
    else exp_errc++;
    step();
    check({tag, " drained"}, 32'(out_valid), 32'd0);
    check({tag, " enc_count"}, 32'(enc_count), 32'(exp_enc));
    check({tag, " err_count"}, 32'(err_count), 32'(exp_errc));
  endtask

  // Burst word k: addi x(k+1), x0, 3k+1.
  function automatic logic [31:0] burst_word(input int k);
    logic [11:0] im;
    logic [4:0]  rd;
    im = 12'(k * 3 + 1);
    rd = 5'(k + 1);
    return {im, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int recv;
    logic hold_pend;
    logic [31:0] hold_w;

    n_vec = 0;
    n_bad = 0;
    exp_enc = 0;
    exp_errc = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    step();
    step();

    // Reset state
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_inst", out_inst, 32'd0);
    check("rst out_err", 32'(out_err), 32'd0);
    check("rst enc_count", 32'(enc_count), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    step();
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    // Each legal format
    single("I addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 3'b000);
    single("S sw", 3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0021A423, 3'b000);
    single("B beq", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3,
           3'b000);
    single("J jal", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 3'b000);
    single("U lui", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7,
           3'b000);
    single("R add", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 32'h002081B3,
           3'b000);
    // Boundary values that still fit
    single("I min", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093,
           3'b000);
    single("J -2", 3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFE, 32'hFFFFF06F,
           3'b000);

    // Error cases emit the NOP
    single("I range", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h00000013,
           3'b001);
    single("B misalign", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h00000013,
           3'b010);
    single("fmt 7", 3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'h00000013, 3'b100);
    single("U low bits", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001,
           32'h00000013, 3'b010);
    single("J range", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h00000013,
           3'b001);

    // Back-to-back burst with out_ready pattern 1,0,0,1 repeating
    sent = 0;
    recv = 0;
    hold_pend = 1'b0;
    hold_w = '0;
    for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (sent < 8) drive(3'd1, 7'h13, 5'(sent + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(sent * 3 + 1));
      else in_valid = 1'b0;
      #1;
      if (hold_pend) begin
        check("burst hold valid", 32'(out_valid), 32'd1);
        check("burst hold inst", out_inst, hold_w);
      end
      check("burst in_ready", 32'(in_ready), 32'(!(((sent - recv) == 2) && !out_ready)));
      if (out_valid && out_ready) begin
        check("burst order", out_inst, burst_word(recv));
        recv++;
      end
      hold_pend = out_valid && !out_ready;
      hold_w = out_inst;
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("burst words received", 32'(recv), 32'd8);
    exp_enc += 8;
    step();
    check("burst enc_count", 32'(enc_count), 32'(exp_enc));
    check("burst err_count", 32'(err_count), 32'(exp_errc));

    // Reset with two words in flight
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step();
    drive(3'd1, 7'h13, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    step();
    in_valid = 1'b0;
    check("full out_valid", 32'(out_valid), 32'd1);
    check("full in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    exp_enc = 0;
    exp_errc = 0;
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    check("mid-rst out_inst", out_inst, 32'd0);
    check("mid-rst out_err", 32'(out_err), 32'd0);
    check("mid-rst enc_count", 32'(enc_count), 32'd0);
    check("mid-rst err_count", 32'(err_count), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    check("after rst in_ready", 32'(in_ready), 32'd1);
    single("after rst", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093,
           3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder: the packing direction of immediate extraction.
- Accepts decoded fields (format, opcode, register indices, funct3/funct7, 32-bit signed/absolute immediate) and emits the 32-bit instruction word.
- Range- and alignment-checks each immediate.
- Used by the test-program loader and self-check harness to build instruction memory images; 2-stage valid/ready pipeline.

Parameters:
- CNT_W, 16, width of the encoded-instruction and error counters.
- NOP_WORD, 32'h00000013, word emitted in place of any instruction that fails checks.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input fields valid.
- in_ready  output  1  encoder can accept fields this cycle.
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 illegal.
- in_opcode  input  7  opcode placed in bits [6:0].
- in_rd / in_rs1 / in_rs2  input  5 each  register indices.
- in_funct3  input  3  funct3.
- in_funct7  input  7  funct7 (R only).
- in_imm  input  32  immediate: signed byte offset for I/S/B/J; full value for U (low 12 bits must be 0).
- out_valid  output  1  out_inst valid.
- out_ready  input  1  downstream accepts.
- out_inst  output  32  encoded word.
- out_err  output  3  [0] range, [1] misalignment, [2] illegal format.
- enc_count  output  CNT_W  error-free words handed off.
- err_count  output  CNT_W  errored words handed off.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_inst=0, out_err=0, enc_count=0, err_count=0, both stage valids=0.
  - Reset mid-transfer drops in-flight words with no output; in_ready=1 once rst_n=1.
- S1 registers the fields and computes check flags. S2 registers the packed word and err.
- Latency: 2 cycles from the accept edge to out_valid with no backpressure; throughput 1/cycle.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = !s1_valid || s1_adv, where s1_adv = !s2_valid || out_ready (combinational through the chain).
  - out_inst and out_err hold stable while out_valid && !out_ready.
  - Data is never dropped or duplicated under any out_ready pattern.
- Checks (i = in_imm):
  - I/S: range error unless i[31:11] is all equal.
  - B: range error unless i[31:12] is all equal; misaligned if i[0].
  - J: range error unless i[31:20] is all equal; misaligned if i[0].
  - U: misaligned if i[11:0] != 0.
  - R: imm ignored, no checks.
  - fmt 6/7: err[2]=1.
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, op}
  - I: {i[11:0], rs1, funct3, rd, op}
  - S: {i[11:5], rs2, rs1, funct3, i[4:0], op}
  - B: {i[12], i[10:5], rs2, rs1, funct3, i[4:1], i[11], op}
  - U: {i[31:12], rd, op}
  - J: {i[20], i[10:1], i[11], i[19:12], rd, op}
- Any err bit set: out_inst = NOP_WORD and out_err reports all applicable bits.
- Counters:
  - On out_valid && out_ready, enc_count++ if out_err==0, else err_count++.
  - Both counters wrap modulo 2^CNT_W.
- Simultaneous accept and handoff in the same cycle: both occur, with no bubble.

Test Plan:
- I, op 0x13, rd=1, rs1=0, f3=0, imm=5 -> 0x00500093 two cycles later, err=0, enc_count=1.
- S, op 0x23, rs1=3, rs2=2, f3=2, imm=8 -> 0x0021A423; B, op 0x63, rs1=0, rs2=0, f3=0, imm=-4 -> 0xFE000EE3.
- J, op 0x6F, rd=1, imm=8 -> 0x008000EF; U, op 0x37, rd=5, imm=0x12345000 -> 0x123452B7; R, op 0x33, rd=3, rs1=1, rs2=2 -> 0x002081B3.
- Errors, each -> 0x00000013 and err_count increments:
  - I, imm=2048 -> err=3'b001.
  - B, imm=3 -> err=3'b010.
  - fmt=7 -> err=3'b100.
- Back-to-back 8 words with out_ready toggling 1,0,0,1,... -> in-order, stable while stalled, in_ready deasserts when both stages are full, enc_count=8.
- rst_n pulsed low with 2 words in flight -> outputs and counters 0 immediately; next accepted word emerges 2 cycles after acceptance.
